// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared constants, field map and types for the fabric configuration loader.
package fpga_cfg_pkg;
    localparam int PROG_W = 116;
    localparam int LOGIC_LO = 0;
    localparam int LOGIC_HI = 19;
    localparam int CONNECT_LO = 20;
    localparam int CONNECT_HI = 51;
    localparam int SWITCH_LO = 52;
    localparam int SWITCH_HI = 115;
    typedef enum logic [1:0] {IDLE, LOAD, CSUM} cfg_state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_PAD = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction
endpackage

// File: rtl/cfg_shadow_reg.sv
// cfg_shadow_reg: byte-addressed shadow register that assembles a configuration word from a byte stream.
module cfg_shadow_reg #(
    parameter int PROG_W = 116,
    parameter int NBYTES = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(NBYTES)-1:0]    idx,
    input  logic [7:0]                   din,
    output logic [PROG_W-1:0]            word,
    output logic [8*NBYTES-PROG_W-1:0]   pad
);
    logic [8*NBYTES-1:0] sh;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sh <= '0;
        else if (we) sh[8*idx +: 8] <= din;
    end
    assign word = sh[PROG_W-1:0];
    assign pad = sh[8*NBYTES-1:PROG_W];
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams a checksummed bitstream into a shadow register and commits it atomically to the fabric.
module fpga_config_loader #(
    parameter int PROG_W = 116,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [PROG_W-1:0] prog_out,
    output logic              cfg_valid,
    output logic              fpga_reset,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    import fpga_cfg_pkg::*;
    localparam int NBYTES = nbytes(PROG_W);
    localparam int IDX_W = $clog2(NBYTES);
    localparam int PAD_W = 8 * NBYTES - PROG_W;
    localparam int TW = $clog2(TIMEOUT_CYC);
    cfg_state_t state;
    logic [IDX_W-1:0] idx;
    logic [7:0] sum;
    logic [TW-1:0] tcnt;
    logic [PROG_W-1:0] word;
    logic [PAD_W-1:0] pad;
    logic hs, tout;
    logic [7:0] fsum;
    assign din_ready = state != IDLE;
    assign hs = din_valid && din_ready;
    assign fsum = sum + din;
    assign tout = din_ready && !hs && tcnt == TW'(TIMEOUT_CYC - 1);
    assign fpga_reset = din_ready || !cfg_valid;
    cfg_shadow_reg #(.PROG_W(PROG_W), .NBYTES(NBYTES)) u_shadow (
        .clk(clk),
        .reset(reset),
        .we(hs && state == LOAD && !start),
        .idx(idx),
        .din(din),
        .word(word),
        .pad(pad)
    );
    // start outranks everything, so a byte arriving with it is dropped without done/err
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            sum <= '0;
            tcnt <= '0;
            prog_out <= '0;
            cfg_valid <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            if (start) begin
                state <= LOAD;
                idx <= '0;
                sum <= '0;
                tcnt <= '0;
                err_code <= ERR_NONE;
            end else if (tout) begin
                state <= IDLE;
                err <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end else if (state != IDLE) begin
                tcnt <= hs ? '0 : tcnt + 1'b1;
                if (hs) begin
                    sum <= fsum;
                    if (state == LOAD) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(NBYTES - 1)) state <= CSUM;
                    end else begin
                        state <= IDLE;
                        if (fsum == 8'h00 && pad == '0) begin
                            prog_out <= word;
                            cfg_valid <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                            err_code <= fsum != 8'h00 ? ERR_CSUM : ERR_PAD;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: scoreboard bench for the configuration loader; expected outcomes are queued per load.
module tb_fpga_config_loader;
    localparam int PROG_W = 116;
    localparam int TIMEOUT_CYC = 1024;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic din_ready, cfg_valid, fpga_reset, done, err;
    logic [PROG_W-1:0] prog_out;
    logic [1:0] err_code;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    typedef struct {
        logic ok;
        logic [1:0] code;
        logic [PROG_W-1:0] prog;
        logic valid;
        int lat;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [7:0] bytes [15];
    logic [PROG_W-1:0] model_prog = '0;
    logic model_valid = 1'b0;

    fpga_config_loader #(.PROG_W(PROG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .prog_out(prog_out),
        .cfg_valid(cfg_valid),
        .fpga_reset(fpga_reset),
        .done(done),
        .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done || err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {126'd0, done, err}, 128'd0);
            end else begin
                cur = sb.pop_front();
                check("pulse", {126'd0, done, err}, cur.ok ? 128'd2 : 128'd1);
                check("err_code", err_code, cur.code);
                check("prog_out", prog_out, cur.prog);
                check("cfg_valid", cfg_valid, cur.valid);
                check("fpga_reset_after", fpga_reset, !cur.valid);
                if (cur.lat != 0) check("latency", cyc - start_cyc, cur.lat);
            end
        end
    end

    function automatic logic [7:0] csum_of();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 15; i++) s = s + bytes[i];
        return 8'h00 - s;
    endfunction

    task automatic push_expect(input logic ok, input logic [1:0] code, input int lat);
        logic [119:0] w;
        exp_t e;
        for (int i = 0; i < 15; i++) w[8*i +: 8] = bytes[i];
        if (ok) begin
            model_prog = w[PROG_W-1:0];
            model_valid = 1'b1;
        end
        e.ok = ok;
        e.code = code;
        e.prog = model_prog;
        e.valid = model_valid;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (din_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("din_ready_wait", 0, 1);
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) begin
            din_valid = 1'b0;
            repeat ($urandom_range(maxgap)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_stream(input logic [7:0] csum, input int maxgap);
        for (int i = 0; i < 15; i++) begin
            gap(maxgap);
            send_byte(bytes[i]);
        end
        gap(maxgap);
        send_byte(csum);
        din_valid = 1'b0;
    endtask

    task automatic wait_sb(input int max);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk); #1;
        end
        check("sb_timeout", sb.size(), 0);
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 15; i++) bytes[i] = 8'($urandom);
        bytes[14] = bytes[14] & 8'h0F;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_prog_out", prog_out, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_fpga_reset", fpga_reset, 1);
        check("rst_din_ready", din_ready, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_err_code", err_code, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        // good back-to-back stream 01..0F with checksum 88
        for (int i = 0; i < 15; i++) bytes[i] = 8'(i + 1);
        push_expect(1'b1, 2'd0, 17);
        check("ready_before_start", din_ready, 0);
        pulse_start();
        check("ready_after_start", din_ready, 1);
        check("fpga_reset_loading", fpga_reset, 1);
        send_stream(8'h88, 0);
        check("done_visible", done, 1);
        check("ready_drop", din_ready, 0);
        wait_sb(20);
        check("t1_cfg_valid", cfg_valid, 1);
        check("t1_fpga_reset", fpga_reset, 0);
        check("t1_byte0", prog_out[7:0], 8'h01);
        check("t1_top_nibble", prog_out[115:112], 4'hF);
        // bad checksum keeps the old configuration
        push_expect(1'b0, 2'd1, 0);
        pulse_start();
        check("t2_fpga_reset_loading", fpga_reset, 1);
        send_stream(8'h89, 0);
        wait_sb(20);
        check("t2_fpga_reset", fpga_reset, 0);
        check("t2_byte0", prog_out[7:0], 8'h01);
        // nonzero pad bits with a good sum
        bytes[14] = 8'h1F;
        push_expect(1'b0, 2'd2, 0);
        pulse_start();
        send_stream(8'h78, 0);
        wait_sb(20);
        // timeout after six bytes
        pulse_start();
        check("start_clears_err_code", err_code, 0);
        push_expect(1'b0, 2'd3, 0);
        for (int i = 0; i < 6; i++) send_byte(bytes[i]);
        din_valid = 1'b0;
        repeat (TIMEOUT_CYC - 2) begin
            @(posedge clk); #1;
        end
        check("no_early_timeout", {err, din_ready}, 2'b01);
        wait_sb(50);
        check("t4_din_ready", din_ready, 0);
        check("t4_err_code", err_code, 3);
        check("t4_fpga_reset", fpga_reset, 0);
        // restart mid-load: only the second stream may commit
        rand_bytes();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(bytes[i]);
        din_valid = 1'b0;
        rand_bytes();
        push_expect(1'b1, 2'd0, 17);
        pulse_start();
        send_stream(csum_of(), 0);
        wait_sb(20);
        // random streams with idle gaps
        for (int n = 0; n < 3; n++) begin
            rand_bytes();
            push_expect(1'b1, 2'd0, 0);
            pulse_start();
            send_stream(csum_of(), 3);
            wait_sb(20);
        end
        // bad sum and bad pad together: checksum reported
        rand_bytes();
        bytes[14] = bytes[14] | 8'hF0;
        push_expect(1'b0, 2'd1, 0);
        pulse_start();
        send_stream(csum_of() + 8'h01, 0);
        wait_sb(20);
        // start coincident with the checksum byte drops the byte
        rand_bytes();
        pulse_start();
        for (int i = 0; i < 15; i++) send_byte(bytes[i]);
        din = csum_of();
        din_valid = 1'b1;
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din_valid = 1'b0;
        check("collide_ready", din_ready, 1);
        check("collide_done_err", {done, err}, 0);
        check("collide_err_code", err_code, 0);
        push_expect(1'b1, 2'd0, 0);
        send_stream(csum_of(), 0);
        wait_sb(20);
        // asynchronous reset while waiting for the checksum byte
        rand_bytes();
        pulse_start();
        for (int i = 0; i < 15; i++) send_byte(bytes[i]);
        din_valid = 1'b0;
        check("pre_rst_cfg_valid", cfg_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        model_prog = '0;
        model_valid = 1'b0;
        check("arst_prog_out", prog_out, 0);
        check("arst_cfg_valid", cfg_valid, 0);
        check("arst_fpga_reset", fpga_reset, 1);
        check("arst_din_ready", din_ready, 0);
        check("arst_done_err", {done, err}, 0);
        check("arst_err_code", err_code, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_fpga_reset", fpga_reset, 1);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

- Loads a configuration bitstream for the 2x2 `fpga` fabric and drives its 116-bit `prog_in` port.
- Accepts a byte stream over a valid/ready handshake, assembles it in a shadow register, and verifies a trailing checksum byte.
- Commits the shadow register atomically to `prog_out` only when the checksum matches.
- Holds the fabric in reset while a load is in progress and until a first good configuration exists.

## Interface
Parameters:
- `PROG_W`, 116: configuration width; must equal the fabric `prog_in` width.
- `TIMEOUT_CYC`, 1024: maximum idle cycles between accepted bytes during a load before the load aborts.
- Localparam `NBYTES` = ceil(`PROG_W`/8) = 15 data bytes.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse; begins a load at byte 0.
- `din` input 8: stream byte.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: loader can accept a byte.
- `prog_out` output `PROG_W`: committed configuration; connects to fabric `prog_in`.
- `cfg_valid` output 1: a checksum-verified configuration has been committed since reset.
- `fpga_reset` output 1: high holds the fabric in reset.
- `done` output 1: one-cycle pulse on a successful commit.
- `err` output 1: one-cycle pulse on a failed load.
- `err_code` output 2: cause of the last failure. 0 = none, 1 = checksum, 2 = pad bits nonzero, 3 = timeout. Holds its value until the next `start`.

## Operation
FSM has three states: IDLE, LOAD, CSUM.
- IDLE: `din_ready`=0.
  - `start` → LOAD. Clears byte counter, running sum, timeout counter and `err_code`.
- LOAD: `din_ready`=1.
  - Each handshake (`din_valid` && `din_ready`) writes byte k into shadow bits [8k+7:8k] and adds it to the 8-bit running sum (mod 256).
  - After byte `NBYTES`-1 is accepted → CSUM.
- CSUM: `din_ready`=1.
  - The accepted byte is added to the sum. Pass condition: final sum == 8'h00 AND shadow bits [119:116] of byte 14 == 0.
  - Pass: `prog_out` ← shadow[115:0], `cfg_valid` ← 1, `done` pulses.
  - Fail: `prog_out` unchanged, `err` pulses, `err_code` set. Checksum failure takes priority over pad failure.
  - Either outcome → IDLE.
- Timeout:
  - In LOAD/CSUM, the counter increments every cycle with no handshake and clears on each handshake.
  - Reaching `TIMEOUT_CYC` → IDLE, `err` pulses, `err_code`=3.
- `start` in LOAD or CSUM restarts the load from byte 0. It is not an error; the partial shadow is discarded and `prog_out` is untouched.
- `start` coincident with a CSUM handshake: `start` wins and the byte is dropped. No `done`/`err` is produced.
- `fpga_reset` = (state != IDLE) || !`cfg_valid`.
- A failed load with a prior valid configuration releases the fabric on the old `prog_out`.

## Timing
- Reset (async, `reset`=0) values:
  - state IDLE, `prog_out`=0, `cfg_valid`=0, `fpga_reset`=1
  - `din_ready`=0, `done`=0, `err`=0, `err_code`=0
- Reset mid-load discards everything. There is no retained configuration.
- `din_ready` is registered and rises the cycle after `start`.
- Back-to-back bytes are accepted at 1 byte/cycle. A minimum load takes 1 + 16 cycles from `start`.
- Commit latency: `prog_out`, `cfg_valid` and `done` update on the edge that accepts the checksum byte, so they are visible the following cycle.
- `fpga_reset` deasserts the same cycle as `done` is visible.
- `prog_out` never changes except on a successful commit or reset. No partial configuration ever reaches the fabric.
- `din_ready` drops the cycle after the checksum byte is accepted.
- `din_valid` with `din_ready`=0 is ignored; data is not held.

## Structure
- Package `fpga_cfg_pkg`:
  - `PROG_W`=116.
  - Field ranges: `LOGIC_LO/HI`=0/19, `CONNECT_LO/HI`=20/51, `SWITCH_LO/HI`=52/115.
  - `typedef enum logic [1:0] {IDLE, LOAD, CSUM} cfg_state_t`.
  - `err_code` encodings as constants.
- One sub-module: `cfg_shadow_reg`. It holds the byte-addressed 120-bit shadow register with write enable and byte index, and exposes the assembled word and pad bits.
- The FSM, sum, timeout counter and commit register live in the top.

## Test plan
- Reset, then load 15 bytes 8'h01..8'h0F and checksum 8'h88 (sum 120 + 136 = 256), streamed back-to-back → `done` at cycle 17 after `start`, `cfg_valid`=1, `fpga_reset`=0, `prog_out[7:0]`=8'h01, `prog_out[115:112]`=4'hF.
- Same stream with checksum 8'h89 → `err`=1, `err_code`=1, `prog_out` holds the prior value, `fpga_reset` returns to its pre-load level.
- Byte 14 = 8'h1F with checksum adjusted so the sum is 0 → `err_code`=2, no commit.
- Stall `din_valid` low for `TIMEOUT_CYC` cycles after byte 5 → `err_code`=3, state IDLE, `din_ready`=0.
- `start` after byte 9, then a full good stream → a single `done`, and `prog_out` equals the second stream only.
- Assert `reset`=0 during CSUM after a prior good commit → all outputs take reset values asynchronously, with `prog_out`=0 and `cfg_valid`=0.
